// File: rtl/ddr_pkg.sv
// Shared types and constants for the output handler: lane state encoding,
// lane counter width and the default lane count.
package ddr_pkg;

    localparam int CNT_W     = 10;
    localparam int DEF_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } lane_state_e;

endpackage

// File: rtl/stretch_lane.sv
// One arrow lane: stretches a single-cycle pulse into a hold of HOLD_MS ticks,
// followed by a GAP_MS-tick forced off-gap. OUTPUT_HANDLER_RETRIGGER_EN enables hold extension.
module stretch_lane
    import ddr_pkg::*;
#(
    parameter int HOLD_MS = 100,
    parameter int GAP_MS  = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pulse,
    output logic out,
    output logic busy
);

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_MS);

    lane_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        expire  = tick && (cnt_q == CNT_W'(1));
        case (state_q)
            IDLE: begin
                if (pulse) begin
                    state_d = ON;
                    cnt_d   = HOLD_CNT;
                end
            end
            ON: begin
`ifdef OUTPUT_HANDLER_RETRIGGER_EN
                if (pulse) begin
                    cnt_d = HOLD_CNT;
                end else
`endif
                if (expire) begin
                    // With no gap configured, a pulse on the expiry tick chains straight into a new hold.
                    if (GAP_MS != 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_CNT;
                    end else if (pend_q || pulse) begin
                        cnt_d  = HOLD_CNT;
                        pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (expire) begin
                    pend_d = 1'b0;
                    if (pend_q || pulse) begin
                        state_d = ON;
                        cnt_d   = HOLD_CNT;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    if (pulse) pend_d = 1'b1;
                    if (tick)  cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        out  = (state_q == ON);
        busy = (state_q != IDLE);
    end

endmodule

// File: rtl/output_handler.sv
// Per-lane pulse stretcher for LEDs/buzzer: shared millisecond prescaler plus LANES
// stretch_lane instances. Optional macro OUTPUT_HANDLER_RETRIGGER_EN (hold extension on re-pulse).
module output_handler
    import ddr_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int CLK_HZ  = 50000000,
    parameter int HOLD_MS = 100,
    parameter int GAP_MS  = 20
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic [LANES-1:0] pulse_in,
    output logic [LANES-1:0] out,
    output logic [LANES-1:0] busy
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Free-running: lanes only observe the tick, they never stall the prescaler.
    always_comb begin
        tick = (ps_q == PS_W'(TICK_DIV - 1));
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        stretch_lane #(
            .HOLD_MS (HOLD_MS),
            .GAP_MS  (GAP_MS)
        ) u_lane (
            .clk   (CLOCK_50),
            .rst_n (Reset),
            .tick  (tick),
            .pulse (pulse_in[g]),
            .out   (out[g]),
            .busy  (busy[g])
        );
    end

endmodule

// File: tb/tb_output_handler.sv
// Bench for output_handler at 10 kHz (10 clocks per tick), HOLD_MS=3, GAP_MS=2,
// plus a second instance with GAP_MS=0.
module tb_output_handler;

    typedef struct {
        int lo;
        int hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pulse, out_w, busy_w;
    logic [3:0] pulse0, out0, busy0;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    output_handler #(.LANES(4), .CLK_HZ(10000), .HOLD_MS(3), .GAP_MS(2)) u_dut (
        .CLOCK_50 (clk),
        .Reset    (rst_n),
        .pulse_in (pulse),
        .out      (out_w),
        .busy     (busy_w)
    );

    output_handler #(.LANES(4), .CLK_HZ(10000), .HOLD_MS(3), .GAP_MS(0)) u_dut0 (
        .CLOCK_50 (clk),
        .Reset    (rst_n),
        .pulse_in (pulse0),
        .out      (out0),
        .busy     (busy0)
    );

    // Leaves the bench 1 ns after the edge on which the prescaler wrapped.
    task automatic align_tick();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (u_dut.tick) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL align_tick: prescaler wrap not observed within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive negedges (starting at the current one) where the condition holds.
    // mode 0: out of u_dut, 1: busy && !out of u_dut, 2: out of u_dut0.
    task automatic count_while(input int lane, input int mode, output int n);
        logic c;
        n = 0;
        while (n < 200) begin
            case (mode)
                0:       c = out_w[lane];
                1:       c = busy_w[lane] && !out_w[lane];
                default: c = out0[lane];
            endcase
            if (!c) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pulse  = '0;
        pulse0 = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            pulse  = 4'($urandom);
            pulse0 = 4'($urandom);
            if (i % 5 == 4) begin
                @(negedge clk);
                vectors++;
                if (out_w !== 4'b0000 || busy_w !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL reset_hold: out=%b busy=%b, want 0000/0000", out_w, busy_w);
                end
            end
        end
        pulse  = '0;
        pulse0 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse[0] = 1'b1;
        @(posedge clk);
        #1;
        pulse[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_on: out[0]=%b, want 1", out_w[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_w !== 4'b0000 || busy_w !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_async: out=%b busy=%b, want 0000/0000 before next edge", out_w, busy_w);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int   n;
        exp_t e;
        align_tick();
        pulse[2] = 1'b1;
        exp_q.push_back('{21, 30});
        exp_q.push_back('{11, 20});
        @(posedge clk);
        #1;
        pulse[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_w[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_rise: out[2]=%b one cycle after pulse, want 1", out_w[2]);
        end
        count_while(2, 0, n);
        e = exp_q.pop_front();
        vectors++;
        if (n < e.lo || n > e.hi) begin
            miscompares++;
            $display("FAIL single_on_len: got %0d cycles, want %0d..%0d", n, e.lo, e.hi);
        end
        count_while(2, 1, n);
        e = exp_q.pop_front();
        vectors++;
        if (n < e.lo || n > e.hi) begin
            miscompares++;
            $display("FAIL single_gap_len: got %0d cycles, want %0d..%0d", n, e.lo, e.hi);
        end
        vectors++;
        if (busy_w[2] !== 1'b0 || out_w[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: busy[2]=%b out[2]=%b, want 0/0", busy_w[2], out_w[2]);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_gap_pending();
        int   n;
        int   on_len[2];
        int   gap_len[2];
        exp_t e;
        bit   extra;
        align_tick();
        pulse[1] = 1'b1;
        exp_q.push_back('{21, 30});
        exp_q.push_back('{11, 20});
        exp_q.push_back('{21, 30});
        exp_q.push_back('{11, 20});
        @(posedge clk);
        #1;
        pulse[1] = 1'b0;
        fork
            begin
                repeat (34) @(posedge clk);
                #1;
                pulse[1] = 1'b1;
                @(posedge clk);
                #1;
                pulse[1] = 1'b0;
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    count_while(1, 0, on_len[k]);
                    count_while(1, 1, gap_len[k]);
                end
            end
        join
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            vectors++;
            if (on_len[k] < e.lo || on_len[k] > e.hi) begin
                miscompares++;
                $display("FAIL pend_on%0d_len: got %0d cycles, want %0d..%0d", k, on_len[k], e.lo, e.hi);
            end
            e = exp_q.pop_front();
            vectors++;
            if (gap_len[k] < e.lo || gap_len[k] > e.hi) begin
                miscompares++;
                $display("FAIL pend_gap%0d_len: got %0d cycles, want %0d..%0d", k, gap_len[k], e.lo, e.hi);
            end
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy_w[1] !== 1'b0 || out_w[1] !== 1'b0) extra = 1;
            @(negedge clk);
        end
        vectors++;
        if (extra) begin
            miscompares++;
            $display("FAIL pend_consumed: lane 1 active again after second gap, want idle");
        end
        n = 0;
    endtask

    task automatic test_retrigger();
        int   n;
        exp_t e;
        align_tick();
        pulse[3] = 1'b1;
`ifdef OUTPUT_HANDLER_RETRIGGER_EN
        exp_q.push_back('{39, 39});
`else
        exp_q.push_back('{29, 29});
`endif
        @(posedge clk);
        #1;
        pulse[3] = 1'b0;
        fork
            begin
                repeat (14) @(posedge clk);
                #1;
                pulse[3] = 1'b1;
                @(posedge clk);
                #1;
                pulse[3] = 1'b0;
            end
            begin
                @(negedge clk);
                count_while(3, 0, n);
            end
        join
        e = exp_q.pop_front();
        vectors++;
        if (n < e.lo || n > e.hi) begin
            miscompares++;
            $display("FAIL retrigger_on_len: got %0d cycles, want %0d", n, e.lo);
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_all_lanes();
        int   n;
        exp_t e;
        align_tick();
        pulse = 4'b1111;
        exp_q.push_back('{21, 30});
        @(posedge clk);
        #1;
        pulse = 4'b0000;
        @(negedge clk);
        vectors++;
        if (out_w !== 4'b1111 || busy_w !== 4'b1111) begin
            miscompares++;
            $display("FAIL all_rise: out=%b busy=%b, want 1111/1111", out_w, busy_w);
        end
        n = 0;
        while (out_w === 4'b1111 && n < 200) begin
            n++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        vectors++;
        if (n < e.lo || n > e.hi || out_w !== 4'b0000) begin
            miscompares++;
            $display("FAIL all_fall: out=%b after %0d cycles, want 0000 after %0d..%0d", out_w, n, e.lo, e.hi);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_gap0();
        int   n;
        exp_t e;
        align_tick();
        pulse0[2] = 1'b1;
        exp_q.push_back('{59, 59});
        @(posedge clk);
        #1;
        pulse0[2] = 1'b0;
        fork
            begin
                repeat (28) @(posedge clk);
                #1;
                pulse0[2] = 1'b1;
                @(posedge clk);
                #1;
                pulse0[2] = 1'b0;
            end
            begin
                @(negedge clk);
                count_while(2, 2, n);
            end
        join
        e = exp_q.pop_front();
        vectors++;
        if (n !== e.lo) begin
            miscompares++;
            $display("FAIL gap0_chain_len: got %0d cycles, want %0d", n, e.lo);
        end
        vectors++;
        if (busy0[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL gap0_chain_busy: busy0[2]=%b when out fell, want 0", busy0[2]);
        end
        repeat (5) @(negedge clk);
        align_tick();
        pulse0[1] = 1'b1;
        exp_q.push_back('{29, 29});
        @(posedge clk);
        #1;
        pulse0[1] = 1'b0;
        @(negedge clk);
        count_while(1, 2, n);
        e = exp_q.pop_front();
        vectors++;
        if (n !== e.lo || busy0[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL gap0_idle: on %0d cycles busy0[1]=%b, want %0d cycles busy 0", n, busy0[1], e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_pending();
        test_retrigger();
        test_all_lanes();
        test_gap0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/output_handler.md
Name: output_handler

Overview:
- Output-side counterpart of the key input handler: takes single-cycle hit/event pulses, one per arrow lane, and turns each into a visible LED level held for a fixed time.
- After the hold, a guaranteed off-gap ensures back-to-back hits blink distinctly.
- Sits between game scoring logic (pulse source) and the board LEDs/buzzer. Clocked by CLOCK_50.

Parameters:
- LANES, 4, number of independent arrow lanes.
- CLK_HZ, 50000000, clock frequency; TICK_DIV = CLK_HZ/1000 clocks per millisecond tick.
- HOLD_MS, 100, on-time in ms ticks; legal range 1..1023.
- GAP_MS, 20, forced off-time in ms ticks after each hold; legal range 0..1023.

Ports:
- CLOCK_50  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- pulse_in  in  LANES  single-cycle event per lane, synchronous to CLOCK_50.
- out  out  LANES  stretched level per lane, to LED/buzzer.
- busy  out  LANES  lane is in ON or GAP state.

Behaviour:
- Reset (Reset=0, async): prescaler=0; every lane in IDLE with counter=0 and pending=0; out=0; busy=0. Deassertion takes effect at the next CLOCK_50 edge.
- Prescaler: one shared counter counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle in which count==TICK_DIV-1. Free-running, never gated by lane activity.
- Per-lane FSM: 10-bit counter, pending bit.
  - IDLE (out=0, busy=0): pulse_in=1 -> ON, counter=HOLD_MS.
  - ON (out=1, busy=1): on tick, counter decrements. On a tick with counter==1:
    - go to GAP with counter=GAP_MS;
    - if GAP_MS==0, go to IDLE instead, or straight to ON if pending.
  - GAP (out=0, busy=1): pulse_in=1 sets pending. On a tick with counter==1:
    - pending=1 -> ON, counter=HOLD_MS, pending cleared;
    - otherwise -> IDLE.
- Outputs are registered. out rises on the clock edge that samples pulse_in, i.e. visible one cycle after the pulse cycle.
- ON duration = HOLD_MS ticks, so (HOLD_MS-1)*TICK_DIV+1 .. HOLD_MS*TICK_DIV cycles depending on tick phase. Same bound applies to GAP with GAP_MS.
- Pulse during ON: behaviour selected by the optional feature below.
- A pulse and a tick in the same cycle: the pulse action wins over the decrement/transition in the state where it applies; pending is set in GAP regardless.
- Pulse on the exact GAP-expiry tick counts as pending, so the lane goes straight to ON.
- Lanes are fully independent. Simultaneous pulses on several lanes are all accepted in the same cycle.
- Multi-cycle high pulse_in is treated as repeated pulses, one per cycle; no internal edge detection.
- Reset mid-ON or mid-GAP: immediate return to the reset values, pending lost.

Optional Feature:
- Macro OUTPUT_HANDLER_RETRIGGER_EN.
- Defined: pulse_in during ON reloads counter=HOLD_MS, extending the hold. State stays ON.
- Undefined: pulse_in during ON is ignored; the hold ends on schedule. GAP/pending behaviour is identical in both builds.

Decomposition:
- Shared package ddr_pkg holds:
  - lane state enum IDLE/ON/GAP (2-bit encoding 00/01/10);
  - counter width constant CNT_W=10;
  - default LANES=4.
- Natural sub-module: stretch_lane (one FSM + counter + pending; inputs tick, pulse; outputs out, busy).
- output_handler contains the prescaler and a generate loop of LANES stretch_lane instances.

Test Plan (CLK_HZ=10000, so TICK_DIV=10; HOLD_MS=3; GAP_MS=2; LANES=4):
- Reset: hold Reset=0 with random pulse_in -> out=0000, busy=0000. Assert Reset mid-ON on lane 0 -> out[0] drops asynchronously, without waiting for a clock edge.
- Single pulse on lane 2 right after a tick -> out[2]=1 the next cycle, high 21..30 cycles. Then busy[2] stays high 11..20 more cycles with out[2]=0, then IDLE.
- Pulse in GAP on lane 1 -> out[1] returns high on the GAP-expiry tick; pending consumed. A second GAP pulse during that ON is handled per the build mode.
- Pulse during ON at counter==2, RETRIGGER build -> ON lasts a further 3 ticks. Non-RETRIGGER build -> ends on the original schedule.
- pulse_in=1111 in one cycle -> all four outs rise the same cycle and fall on the same tick.
- GAP_MS=0 build, pulse at hold expiry -> out stays high continuously. Without a pulse -> IDLE directly, busy falls with out.
